// File: rtl/home_inventory_pkg.sv
// Shared definitions for the load-cell ADC capture path.
package home_inventory_pkg;

  localparam int unsigned ADC_WORD_BITS = 24;
  localparam int unsigned ADC_MAX_CH    = 4;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    COMMIT
  } capture_state_e;

  // Replicate bit (bits-1) of a right-aligned word up to bit 31.
  function automatic logic [31:0] sign_extend(input logic [31:0] word,
                                              input int unsigned bits);
    logic signed [31:0] tmp;
    tmp = signed'(word << (32 - bits));
    return unsigned'(tmp >>> (32 - bits));
  endfunction

endpackage

// File: rtl/home_inventory_sync_edge.sv
// Two-flop synchronizer with an optional falling-edge strobe.
module home_inventory_sync_edge #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Resolve metastability, then keep one extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign dout = sync;
  assign fall = EDGE_EN ? (prev & ~sync) : 1'b0;

endmodule

// File: rtl/home_inventory_adc_capture.sv
// SPI frame-capture engine: one status word plus nch channel words per DRDY.
module home_inventory_adc_capture
  import home_inventory_pkg::*;
#(
  parameter int unsigned MAX_CH    = ADC_MAX_CH,
  parameter int unsigned WORD_BITS = ADC_WORD_BITS,
  parameter int unsigned SCLK_DIV  = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  enable,
  input  logic [3:0]            num_ch,
  input  logic                  adc_drdy_n,
  input  logic                  adc_miso,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic                  adc_mosi,
  output logic [32*MAX_CH-1:0]  raw_data,
  output logic                  frame_valid,
  output logic [31:0]           frame_count,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  busy
);

  localparam int unsigned      DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [4:0]       BIT_LAST = 5'(WORD_BITS - 1);
  localparam logic [3:0]       MAX_NCH  = 4'(MAX_CH);

  capture_state_e state;
  capture_state_e state_nx;

  logic                 drdy_fall;
  logic                 drdy_level_unused;
  logic                 miso_s;
  logic                 miso_fall_unused;

  logic [DIV_W-1:0]     div_cnt;
  logic                 phase_hi;
  logic                 phase_nx;
  logic [4:0]           bit_idx;
  logic [3:0]           word_idx;
  logic [3:0]           nch;
  logic [3:0]           nch_eff;
  logic [WORD_BITS-2:0] shift_sr;
  logic [WORD_BITS-1:0] new_word;
  logic [32*MAX_CH-1:0] shadow;

  logic div_last;
  logic last_bit;
  logic sample;
  logic bit_end;
  logic commit_go;

  home_inventory_sync_edge #(.EDGE_EN(1'b1)) u_sync_drdy (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .din  (adc_drdy_n),
    .dout (drdy_level_unused),
    .fall (drdy_fall)
  );

  home_inventory_sync_edge #(.EDGE_EN(1'b0)) u_sync_miso (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .din  (adc_miso),
    .dout (miso_s),
    .fall (miso_fall_unused)
  );

  assign nch_eff   = ((num_ch == 4'd0) || (num_ch > MAX_NCH)) ? MAX_NCH : num_ch;
  assign div_last  = (div_cnt == DIV_LAST);
  assign last_bit  = (word_idx == nch) && (bit_idx == BIT_LAST);
  assign sample    = (state == SHIFT) && phase_hi && div_last;
  assign bit_end   = (state == SHIFT) && !phase_hi && div_last;
  assign commit_go = (state == CS_HOLD) && div_last && enable;
  assign new_word  = {shift_sr, miso_s};
  assign busy      = (state != IDLE);
  assign adc_mosi  = 1'b0;

  // Next-state and SCLK phase decode; enable low aborts any active frame.
  always_comb begin
    state_nx = state;
    phase_nx = phase_hi;
    unique case (state)
      IDLE:     if (drdy_fall && enable) state_nx = CS_SETUP;
      CS_SETUP: if (div_last)            state_nx = SHIFT;
      SHIFT:    if (bit_end && last_bit) state_nx = CS_HOLD;
      CS_HOLD:  if (div_last)            state_nx = COMMIT;
      COMMIT:                            state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
    if ((state != IDLE) && !enable) state_nx = IDLE;

    if (state_nx != SHIFT)   phase_nx = 1'b0;
    else if (state != SHIFT) phase_nx = 1'b1;
    else if (div_last)       phase_nx = ~phase_hi;
  end

  // Sequencer: state, bit timing, SPI pins and per-channel shadow capture.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      div_cnt  <= '0;
      phase_hi <= 1'b0;
      bit_idx  <= '0;
      word_idx <= '0;
      nch      <= '0;
      shift_sr <= '0;
      shadow   <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
    end else begin
      state    <= state_nx;
      phase_hi <= phase_nx;
      adc_cs_n <= !(state_nx inside {CS_SETUP, SHIFT, CS_HOLD});
      adc_sclk <= (state_nx == SHIFT) && phase_nx;

      if ((state_nx != state) || div_last) div_cnt <= '0;
      else                                 div_cnt <= div_cnt + DIV_W'(1);

      if ((state == IDLE) && (state_nx == CS_SETUP)) begin
        nch      <= nch_eff;
        word_idx <= '0;
        bit_idx  <= '0;
      end

      if (bit_end) begin
        if (bit_idx == BIT_LAST) begin
          bit_idx  <= '0;
          word_idx <= word_idx + 4'd1;
        end else begin
          bit_idx  <= bit_idx + 5'd1;
        end
      end

      // Word 0 is the status word and never reaches a shadow slot.
      if (sample) begin
        shift_sr <= new_word[WORD_BITS-2:0];
        if (bit_idx == BIT_LAST) begin
          for (int unsigned c = 0; c < MAX_CH; c++) begin
            if (word_idx == 4'(c + 1))
              shadow[32*c +: 32] <= sign_extend(32'(new_word), WORD_BITS);
          end
        end
      end
    end
  end

  // Commit captured channels, count frames and track DRDY overruns.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      raw_data    <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      frame_valid <= commit_go;
      if (commit_go) begin
        frame_count <= frame_count + 32'd1;
        for (int unsigned c = 0; c < MAX_CH; c++) begin
          if (4'(c) < nch) raw_data[32*c +: 32] <= shadow[32*c +: 32];
        end
      end
      if (drdy_fall && (state != IDLE)) overrun <= 1'b1;
      else if (overrun_clr)             overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_home_inventory_adc_capture.sv
// Scoreboard bench for home_inventory_adc_capture with a behavioural ADC.
module tb_home_inventory_adc_capture;

  localparam int unsigned NCH = 4;
  localparam int unsigned WB  = 24;
  localparam int unsigned DIV = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [3:0]   num_ch;
  logic         adc_drdy_n;
  logic         adc_miso;
  logic         overrun_clr;
  logic         adc_cs_n;
  logic         adc_sclk;
  logic         adc_mosi;
  logic [127:0] raw_data;
  logic         frame_valid;
  logic [31:0]  frame_count;
  logic         overrun;
  logic         busy;

  home_inventory_adc_capture #(
    .MAX_CH   (NCH),
    .WORD_BITS(WB),
    .SCLK_DIV (DIV)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .enable     (enable),
    .num_ch     (num_ch),
    .adc_drdy_n (adc_drdy_n),
    .adc_miso   (adc_miso),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .adc_mosi   (adc_mosi),
    .raw_data   (raw_data),
    .frame_valid(frame_valid),
    .frame_count(frame_count),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] raw;
    logic [31:0]  count;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           sclk_edges = 0;
  int           valid_pulses = 0;
  int           bitcnt = 0;
  int           cs_fall_cyc = 0;
  int           valid_cyc = 0;
  logic         prev_cs = 1'b1;
  logic [215:0] adc_stream = '0;

  // Frame data: status, ch0..ch3, then zero padding (MSB first).
  localparam logic [215:0] S1 = {24'hAAAAAA, 24'h001001, 24'hFFFFFE, 24'h7FFFFF, 24'h800000, 96'h0};
  localparam logic [127:0] R1 = {32'hFF800000, 32'h007FFFFF, 32'hFFFFFFFE, 32'h00001001};
  localparam logic [215:0] S2 = {24'h5A5A5A, 24'h123456, 24'hABCDEF, 24'h000001, 24'h7FFFFE, 96'h0};
  localparam logic [127:0] R2 = {32'h007FFFFE, 32'h00000001, 32'hFFABCDEF, 32'h00123456};
  localparam logic [215:0] S3 = {24'h000000, 24'hFFFFFF, 24'h400000, 24'hC00000, 24'h00007F, 96'h0};
  localparam logic [127:0] R3 = {32'h0000007F, 32'hFFC00000, 32'h00400000, 32'hFFFFFFFF};
  localparam logic [215:0] S4 = {24'hF0F0F0, 24'h800001, 24'h0F0F0F, 24'h111111, 24'h222222, 96'h0};
  localparam logic [127:0] R4 = {32'h0000007F, 32'hFFC00000, 32'h000F0F0F, 32'hFF800001};
  localparam logic [215:0] S5 = {24'h000000, 24'h000010, 24'h000020, 24'h000030, 24'h000040, 96'h0};
  localparam logic [127:0] R5 = {32'h00000040, 32'h00000030, 32'h00000020, 32'h00000010};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ADC model: present MSB when CS falls, advance one bit per SCLK fall.
  always @(posedge adc_cs_n or negedge adc_sclk) begin
    if (adc_cs_n) bitcnt = 0;
    else          bitcnt = bitcnt + 1;
  end
  assign adc_miso = (bitcnt < 216) ? adc_stream[215 - bitcnt] : 1'b0;

  always @(posedge clk) cyc++;
  always @(posedge adc_sclk) sclk_edges++;

  // Monitor: every frame_valid pops one expected frame from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (prev_cs && !adc_cs_n) cs_fall_cyc = cyc;
    prev_cs = adc_cs_n;
    if (frame_valid) begin
      valid_pulses++;
      valid_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_frame_valid", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("raw_data", raw_data, e.raw);
        check("frame_count", frame_count, e.count);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drdy_pulse();
    adc_drdy_n = 1'b0;
    tick(4);
    adc_drdy_n = 1'b1;
  endtask

  task automatic expect_frame(input logic [127:0] r, input logic [31:0] c);
    exp_t e;
    e.raw   = r;
    e.count = c;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!busy && n < 20) begin tick(1); n++; end
    check({tag, "_started"}, busy, 1'b1);
    n = 0;
    while (busy && n < 3000) begin tick(1); n++; end
    check({tag, "_finished"}, busy, 1'b0);
    tick(2);
  endtask

  task automatic run_frame(input logic [215:0] s, input logic [127:0] r, input logic [31:0] c,
                           input int edges, input string tag);
    adc_stream = s;
    expect_frame(r, c);
    sclk_edges = 0;
    drdy_pulse();
    wait_done(tag);
    check({tag, "_sclk_edges"}, edges, edges == sclk_edges ? edges : sclk_edges);
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b1; num_ch = 4'd4; adc_drdy_n = 1'b0; overrun_clr = 1'b0;
    tick(5);
    check("rst_cs_n", adc_cs_n, 1'b1);
    check("rst_sclk", adc_sclk, 1'b0);
    check("rst_mosi", adc_mosi, 1'b0);
    check("rst_raw", raw_data, 128'h0);
    check("rst_count", frame_count, 32'h0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    adc_drdy_n = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(10);
    check("no_frame_from_reset_drdy", busy, 1'b0);
    check("no_valid_after_reset", valid_pulses, 0);

    // Nominal 4-channel frame
    num_ch = 4'd4;
    run_frame(S1, R1, 32'd1, 120, "nominal");
    check("nominal_frame_len", valid_cyc - cs_fall_cyc, 484);
    check("nominal_valid_pulses", valid_pulses, 1);

    // Out-of-range channel counts fall back to all channels
    num_ch = 4'd0;
    run_frame(S2, R2, 32'd2, 120, "nch0");
    num_ch = 4'd9;
    run_frame(S3, R3, 32'd3, 120, "nch9");

    // Partial frame leaves upper channels untouched
    num_ch = 4'd2;
    run_frame(S4, R4, 32'd4, 72, "nch2");

    // Overrun during a frame; num_ch change mid-frame is ignored
    num_ch = 4'd4;
    adc_stream = S5;
    expect_frame(R5, 32'd5);
    sclk_edges = 0;
    drdy_pulse();
    tick(50);
    num_ch = 4'd1;
    drdy_pulse();
    tick(2);
    check("overrun_set", overrun, 1'b1);
    wait_done("overrun");
    check("overrun_sclk_edges", sclk_edges, 120);
    num_ch = 4'd4;
    tick(20);
    check("overrun_no_queued_frame", frame_count, 32'd5);
    check("overrun_idle", busy, 1'b0);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("overrun_clr_alone", overrun, 1'b0);

    // Clear coinciding with a new overrun edge: set wins
    adc_stream = S1;
    expect_frame(R1, 32'd6);
    sclk_edges = 0;
    drdy_pulse();
    tick(20);
    adc_drdy_n = 1'b0;
    tick(2);
    overrun_clr = 1'b1;
    tick(1);
    check("overrun_set_wins", overrun, 1'b1);
    overrun_clr = 1'b0;
    adc_drdy_n = 1'b1;
    tick(1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("overrun_clr_again", overrun, 1'b0);
    wait_done("setwins");
    check("setwins_sclk_edges", sclk_edges, 120);

    // Abort by dropping enable mid-shift
    adc_stream = S2;
    sclk_edges = 0;
    drdy_pulse();
    n = 0;
    while (sclk_edges < 30 && n < 1000) begin tick(1); n++; end
    check("abort_reached_bit30", sclk_edges >= 30, 1'b1);
    enable = 1'b0;
    tick(1);
    check("abort_cs_n", adc_cs_n, 1'b1);
    check("abort_sclk", adc_sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    tick(10);
    check("abort_count", frame_count, 32'd6);
    check("abort_raw", raw_data, R1);
    check("abort_no_valid", valid_pulses, 6);
    enable = 1'b1;
    tick(2);
    run_frame(S3, R3, 32'd7, 120, "post_abort");

    // Reset in the middle of SHIFT with overrun pending
    adc_stream = S4;
    sclk_edges = 0;
    drdy_pulse();
    tick(6);
    drdy_pulse();
    tick(2);
    check("pre_reset_overrun", overrun, 1'b1);
    n = 0;
    while (sclk_edges < 10 && n < 1000) begin tick(1); n++; end
    check("reset_reached_bit10", sclk_edges >= 10, 1'b1);
    rst = 1'b1;
    tick(1);
    check("midrst_cs_n", adc_cs_n, 1'b1);
    check("midrst_sclk", adc_sclk, 1'b0);
    check("midrst_raw", raw_data, 128'h0);
    check("midrst_count", frame_count, 32'h0);
    check("midrst_overrun", overrun, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", frame_valid, 1'b0);
    rst = 1'b0;
    tick(5);
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
